// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the byte-serial memory bus responder.
package serial_bus_pkg;

  localparam int unsigned BUS_W  = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    PC_LO,
    ADDR_LO,
    ADDR_CHK,
    DATA_LO,
    DELAY,
    RESP_RDY,
    RESP_HI,
    RESP_LO
  } resp_state_t;

  typedef enum logic {
    FETCH,
    LOAD
  } req_kind_t;

  // A bus word as it travels: high byte first.
  typedef struct packed {
    logic [BUS_W-1:0] hi;
    logic [BUS_W-1:0] lo;
  } bus_word_t;

  // Delay counter width; always at least one bit so RESP_DELAY=0 still builds.
  function automatic int unsigned cnt_width(input int unsigned delay);
    return (delay < 2) ? 1 : $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/serial_mem_responder_if.sv
// CPU-side byte-serial bus: request strobes in, response beats out.
interface serial_mem_responder_if;
  import serial_bus_pkg::*;

  logic [BUS_W-1:0] bus_in;
  logic             bus_pc;
  logic             bus_mar;
  logic             bus_mdr;
  logic             ard_receive_ready;
  logic             ard_data_ready;
  logic [BUS_W-1:0] dout;
  logic             dout_valid;

  modport master (
    output bus_in, bus_pc, bus_mar, bus_mdr,
    input  ard_receive_ready, ard_data_ready, dout, dout_valid
  );

  modport slave (
    input  bus_in, bus_pc, bus_mar, bus_mdr,
    output ard_receive_ready, ard_data_ready, dout, dout_valid
  );
endinterface

// File: rtl/sresp_ram.sv
// Word RAM with a store port and a host preload port, one synchronous read port.
module sresp_ram
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_we,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [WORD_W-1:0] st_wdata,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WORD_W-1:0] host_wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Store write is issued last so it overrides a host write to the same index.
  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (st_we)   mem[st_addr]   <= st_wdata;
  end

  // Read samples the array before this edge's writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/serial_mem_responder.sv
// Memory-side responder for the CPU byte-serial bus: fetch/load replies and stores.
// Optional sticky protocol checker enabled by defining SERIAL_RESP_ERR_EN.
module serial_mem_responder
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RESP_DELAY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_mem_responder_if.slave   sbus,
  input  logic                    host_we,
  input  logic [ADDR_W-1:0]       host_addr,
  input  logic [WORD_W-1:0]       host_wdata,
  output logic                    error
);

  localparam int unsigned CNT_W = cnt_width(RESP_DELAY);

  resp_state_t       state_q, state_d;
  bus_word_t         addr_q;
  logic [BUS_W-1:0]  data_hi_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q, ready_d;
  logic              data_ready_q, data_ready_d;
  logic              dout_valid_q, dout_valid_d;
  logic [BUS_W-1:0]  dout_q, dout_d;
  logic [WORD_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_idx;
  logic              st_we;
  logic              rd_en;
  logic              delay_done;

  assign ram_idx    = ADDR_W'(addr_q);
  assign st_we      = (state_q == DATA_LO);
  // Read once, on the first DELAY cycle, so later host writes cannot leak in.
  assign rd_en      = (state_q == DELAY) && (cnt_q == CNT_W'(RESP_DELAY));
  assign delay_done = (cnt_q <= CNT_W'(1));

  sresp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_we      (st_we),
    .st_addr    (ram_idx),
    .st_wdata   ({data_hi_q, sbus.bus_in}),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .rd_en      (rd_en),
    .rd_addr    (ram_idx),
    .rd_data    (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    data_ready_d = 1'b0;
    dout_valid_d = 1'b0;
    dout_d       = '0;
    case (state_q)
      IDLE: begin
        if (sbus.bus_pc)       state_d = PC_LO;
        else if (sbus.bus_mar) state_d = ADDR_LO;
      end
      PC_LO:    state_d = DELAY;
      ADDR_LO:  state_d = ADDR_CHK;
      ADDR_CHK: state_d = sbus.bus_mdr ? DATA_LO : DELAY;
      DATA_LO:  state_d = IDLE;
      DELAY:    if (delay_done) state_d = RESP_RDY;
      RESP_RDY: state_d = RESP_HI;
      RESP_HI:  state_d = RESP_LO;
      RESP_LO:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    ready_d      = (state_d == IDLE);
    data_ready_d = (state_d == RESP_RDY);
    if (state_d == RESP_HI) begin
      dout_valid_d = 1'b1;
      dout_d       = rd_data[WORD_W-1:BUS_W];
    end else if (state_d == RESP_LO) begin
      dout_valid_d = 1'b1;
      dout_d       = rd_data[BUS_W-1:0];
    end
  end

  // Output registers, captured request bytes and the response delay counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      data_ready_q <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      addr_q       <= '0;
      data_hi_q    <= '0;
      cnt_q        <= '0;
    end else begin
      ready_q      <= ready_d;
      data_ready_q <= data_ready_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      if (state_q == IDLE && (sbus.bus_pc || sbus.bus_mar)) addr_q.hi <= sbus.bus_in;
      if (state_q == PC_LO || state_q == ADDR_LO)          addr_q.lo <= sbus.bus_in;
      if (state_q == ADDR_CHK && sbus.bus_mdr)              data_hi_q <= sbus.bus_in;
      if (state_d == DELAY && state_q != DELAY)  cnt_q <= CNT_W'(RESP_DELAY);
      else if (state_q == DELAY && cnt_q != '0)  cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign sbus.ard_receive_ready = ready_q;
  assign sbus.ard_data_ready    = data_ready_q;
  assign sbus.dout              = dout_q;
  assign sbus.dout_valid        = dout_valid_q;

`ifdef SERIAL_RESP_ERR_EN
  logic              err_q;
  logic              err_set;
  logic [1:0]        n_strobe;
  logic [WORD_W-1:0] addr_full;

  // Protocol violations observed this cycle.
  always_comb begin
    n_strobe  = 2'(sbus.bus_pc) + 2'(sbus.bus_mar) + 2'(sbus.bus_mdr);
    addr_full = {addr_q.hi, sbus.bus_in};
    err_set   = (n_strobe > 2'd1);
    case (state_q)
      PC_LO, ADDR_LO: begin
        if (n_strobe == 2'd0 || (addr_full >> ADDR_W) != '0) err_set = 1'b1;
      end
      ADDR_CHK, DATA_LO, DELAY, RESP_RDY, RESP_HI, RESP_LO: begin
        if (sbus.bus_pc || sbus.bus_mar) err_set = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_mem_responder.sv
// Bench for serial_mem_responder: two instances (RESP_DELAY=2 and 0) share one stimulus stream.
module tb_serial_mem_responder;

  localparam int unsigned ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bus_in = '0;
  logic        bus_pc = 1'b0, bus_mar = 1'b0, bus_mdr = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;

  int tests = 0;
  int fails = 0;

  logic [15:0] model [256];

  serial_mem_responder_if sb2 ();
  serial_mem_responder_if sb0 ();

  assign sb2.bus_in = bus_in;  assign sb0.bus_in = bus_in;
  assign sb2.bus_pc = bus_pc;  assign sb0.bus_pc = bus_pc;
  assign sb2.bus_mar = bus_mar; assign sb0.bus_mar = bus_mar;
  assign sb2.bus_mdr = bus_mdr; assign sb0.bus_mdr = bus_mdr;

  logic [1:0] err_w;
  logic [1:0] rr_w, drdy_w, dv_w;
  logic [7:0] dout_w [2];

  assign rr_w   = {sb0.ard_receive_ready, sb2.ard_receive_ready};
  assign drdy_w = {sb0.ard_data_ready, sb2.ard_data_ready};
  assign dv_w   = {sb0.dout_valid, sb2.dout_valid};
  assign dout_w[0] = sb2.dout;
  assign dout_w[1] = sb0.dout;

  serial_mem_responder #(.ADDR_W(ADDR_W), .RESP_DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .sbus(sb2),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .error(err_w[0])
  );

  serial_mem_responder #(.ADDR_W(ADDR_W), .RESP_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sbus(sb0),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .error(err_w[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pre_idx;
    logic [15:0] pre_data;
    bit          fetch;
    logic [15:0] addr;
    logic [15:0] exp_word;
    int          exp_rdy2;
    int          exp_rdy0;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycles from the last request beat to ard_data_ready.
  function automatic int exp_rdy(input int delay, input bit fetch);
    return ((delay == 0) ? 1 : delay) + 1 + (fetch ? 0 : 1);
  endfunction

  task automatic beat(input logic [7:0] b, input bit pc, input bit mar, input bit mdr);
    bus_in = b; bus_pc = pc; bus_mar = mar; bus_mdr = mdr;
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    bus_in = '0; bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0;
  endtask

  task automatic hwrite(input logic [7:0] idx, input logic [15:0] data);
    host_we = 1'b1; host_addr = idx; host_wdata = data;
    @(posedge clk); #1;
    host_we = 1'b0;
    model[idx] = data;
  endtask

  task automatic do_read(input bit fetch, input logic [15:0] addr, input logic [15:0] exp_word,
                         input int exp_r2, input int exp_r0,
                         input bit hw_en, input logic [15:0] hw_data, input string tag);
    int rdy_k [2], rdy_n [2], hi_k [2], val_n [2], rr_k [2];
    logic [15:0] word [2];
    bit stray [2];
    int exp_r;
    for (int i = 0; i < 2; i++) begin
      rdy_k[i] = 0; rdy_n[i] = 0; hi_k[i] = 0; val_n[i] = 0; rr_k[i] = 0;
      word[i] = '0; stray[i] = 1'b0;
    end
    beat(addr[15:8], fetch, !fetch, 1'b0);
    beat(addr[7:0],  fetch, !fetch, 1'b0);
    bus_idle();
    if (hw_en) begin
      host_we = 1'b1; host_addr = addr[7:0]; host_wdata = hw_data;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (drdy_w[i]) begin
          rdy_n[i]++;
          if (rdy_k[i] == 0) rdy_k[i] = k;
        end
        if (dv_w[i]) begin
          val_n[i]++;
          if (val_n[i] == 1) begin hi_k[i] = k; word[i][15:8] = dout_w[i]; end
          else word[i][7:0] = dout_w[i];
        end else if (dout_w[i] != 8'h00) stray[i] = 1'b1;
        if (rr_w[i] && rr_k[i] == 0) rr_k[i] = k;
      end
      if (k == 1 && hw_en) begin
        @(posedge clk); #1;
        host_we = 1'b0;
        model[addr[7:0]] = hw_data;
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      exp_r = (i == 0) ? exp_r2 : exp_r0;
      check($sformatf("%s_d%0d_rdy_cycle", tag, i), rdy_k[i], exp_r);
      check($sformatf("%s_d%0d_rdy_pulses", tag, i), rdy_n[i], 1);
      check($sformatf("%s_d%0d_word", tag, i), word[i], exp_word);
      check($sformatf("%s_d%0d_beats", tag, i), val_n[i], 2);
      check($sformatf("%s_d%0d_hi_cycle", tag, i), hi_k[i], exp_r + 1);
      check($sformatf("%s_d%0d_ready_back", tag, i), rr_k[i], exp_r + 3);
      check($sformatf("%s_d%0d_dout_idle_zero", tag, i), stray[i], 0);
    end
  endtask

  task automatic do_store(input logic [7:0] idx, input logic [15:0] data,
                          input bit coll, input logic [15:0] coll_data, input string tag);
    logic [1:0] rr_k1;
    bit any_resp;
    any_resp = 1'b0;
    rr_k1 = '0;
    beat(8'h00, 1'b0, 1'b1, 1'b0);
    beat(idx,   1'b0, 1'b1, 1'b0);
    beat(data[15:8], 1'b0, 1'b0, 1'b1);
    if (coll) begin
      host_we = 1'b1; host_addr = idx; host_wdata = coll_data;
    end
    beat(data[7:0], 1'b0, 1'b0, 1'b1);
    host_we = 1'b0;
    bus_idle();
    model[idx] = data;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) rr_k1 = rr_w;
      if (drdy_w != 2'b00 || dv_w != 2'b00) any_resp = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_ready_after"}, rr_k1, 2'b11);
    check({tag, "_no_response"}, any_resp, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_err;
    vecs[0] = '{8'h05, 16'hA1B2, 1'b1, 16'h0005, 16'hA1B2, 3, 2};
    vecs[1] = '{8'h10, 16'h1234, 1'b0, 16'h0010, 16'h1234, 4, 3};
    vecs[2] = '{8'hFF, 16'hFFFF, 1'b1, 16'h00FF, 16'hFFFF, 3, 2};
    vecs[3] = '{8'h00, 16'h8001, 1'b0, 16'h0000, 16'h8001, 4, 3};

    // Reset values, then ready from the first cycle after release.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {rr_w, drdy_w, dv_w, dout_w[0], dout_w[1], err_w}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_ready", rr_w, 2'b11);
    check("post_reset_quiet", {drdy_w, dv_w, dout_w[0], dout_w[1], err_w}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) hwrite(8'(i), 16'($urandom));

    foreach (vecs[i]) begin
      hwrite(vecs[i].pre_idx, vecs[i].pre_data);
      do_read(vecs[i].fetch, vecs[i].addr, vecs[i].exp_word,
              vecs[i].exp_rdy2, vecs[i].exp_rdy0, 1'b0, 16'h0, $sformatf("vec%0d", i));
    end

    do_store(8'h10, 16'hDEAD, 1'b0, 16'h0, "store");
    do_read(1'b0, 16'h0010, 16'hDEAD, 4, 3, 1'b0, 16'h0, "load_back");

    do_store(8'h20, 16'h5A5A, 1'b1, 16'h0F0F, "collide");
    do_read(1'b0, 16'h0020, 16'h5A5A, 4, 3, 1'b0, 16'h0, "collide_rd");

    hwrite(8'h30, 16'h1111);
    do_read(1'b1, 16'h0030, 16'h1111, 3, 2, 1'b1, 16'h2222, "rbw_old");
    do_read(1'b1, 16'h0030, 16'h2222, 3, 2, 1'b0, 16'h0, "rbw_new");

    for (int n = 0; n < 40; n++) begin
      int op;
      logic [7:0] idx;
      op  = int'($urandom_range(0, 2));
      idx = 8'($urandom_range(0, 255));
      if (op == 0) do_store(idx, 16'($urandom), 1'b0, 16'h0, "rnd_st");
      else do_read(op == 1, {8'h00, idx}, model[idx], exp_rdy(2, op == 1),
                   exp_rdy(0, op == 1), 1'b0, 16'h0, "rnd_rd");
    end

    // Upper address bits are ignored for indexing.
    check("no_error_before_wrap", err_w, 2'b00);
    do_read(1'b0, 16'h0105, model[8'h05], 4, 3, 1'b0, 16'h0, "wrap");
`ifdef SERIAL_RESP_ERR_EN
    exp_err = 2'b11;
`else
    exp_err = 2'b00;
`endif
    check("wrap_error", err_w, exp_err);
    repeat (3) @(posedge clk);
    #1;
    check("wrap_error_sticky", err_w, exp_err);

    // Reset during the DATA_LO beat of a store.
    beat(8'h00, 1'b0, 1'b1, 1'b0);
    beat(8'h10, 1'b0, 1'b1, 1'b0);
    beat(8'hBE, 1'b0, 1'b0, 1'b1);
    bus_in = 8'hEF; bus_mdr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midstore_reset_outputs", {rr_w, drdy_w, dv_w, dout_w[0], dout_w[1], err_w}, 0);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("midstore_reset_held", {rr_w, drdy_w, dv_w, dout_w[0], dout_w[1], err_w}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midstore_ready_after", rr_w, 2'b11);
    @(posedge clk); #1;
    do_read(1'b0, 16'h0010, model[8'h10], 4, 3, 1'b0, 16'h0, "midstore_unchanged");
    check("error_cleared", err_w, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_mem_responder.md
Name: serial_mem_responder

Overview:
- Memory-side end of the CPU's byte-serial memory bus; stands in for the Arduino.
- Accepts the 2-beat PC or MAR word the CPU control shifts out, then either:
  - returns a 16-bit instruction or load word as two response beats, or
  - absorbs two MDR beats and writes them as a store.
- Used for simulation and FPGA bring-up of the CPU without external hardware.
- Holds an internal word RAM; a host preload port fills it before the CPU runs.

Parameters:
- ADDR_W, 8, RAM index width; DEPTH = 2**ADDR_W 16-bit words.
- RESP_DELAY, 2, idle cycles between the last request beat and ard_data_ready; 0 is legal.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_in  in  8  CPU serial bus byte.
- bus_pc  in  1  CPU is driving a PC beat on bus_in.
- bus_mar  in  1  CPU is driving an address beat.
- bus_mdr  in  1  CPU is driving a store-data beat.
- ard_receive_ready  out  1  responder can accept a new request.
- ard_data_ready  out  1  one-cycle pulse; response beats follow.
- dout  out  8  response byte.
- dout_valid  out  1  dout holds a response beat this cycle.
- host_we  in  1  host preload write strobe.
- host_addr  in  ADDR_W  preload word index.
- host_wdata  in  16  preload word.
- error  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, except ard_receive_ready=1 from the first cycle after reset.
  - Captured address/data registers and the delay counter are 0.
  - RAM contents are not reset.
  - Reset mid-transaction abandons the transaction; no partial RAM write occurs.
- Word format: 16-bit words, high byte first, one byte per cycle. RAM index = captured 16-bit address[ADDR_W-1:0]; upper bits ignored (wrap).
- IDLE: ard_receive_ready=1.
  - bus_pc: capture hi byte, go to PC_LO.
  - Else bus_mar: capture hi byte, go to ADDR_LO.
  - bus_pc has priority over bus_mar; bus_mdr alone is ignored.
- PC_LO: capture lo byte regardless of strobes; kind=FETCH; go to DELAY.
- ADDR_LO: capture lo byte; go to ADDR_CHK.
- ADDR_CHK:
  - bus_mdr=1: capture data hi byte, go to DATA_LO.
  - Else: kind=LOAD, go to DELAY. This cycle does not count toward RESP_DELAY.
- DATA_LO: capture data lo byte; RAM written at the end of this cycle; go to IDLE. No response is sent for a store.
- DELAY:
  - Counter loads RESP_DELAY on entry and decrements each cycle; exit to RESP_RDY when it reaches 0.
  - RESP_DELAY=0: DELAY lasts exactly 1 cycle.
  - RAM read is issued here; read data is registered before RESP_RDY.
- RESP_RDY: ard_data_ready=1 for exactly one cycle; go to RESP_HI.
- RESP_HI: dout=word[15:8], dout_valid=1; go to RESP_LO.
- RESP_LO: dout=word[7:0], dout_valid=1; go to IDLE.
- Response latency, last request beat to first response beat: RESP_DELAY+2 cycles for FETCH, RESP_DELAY+3 cycles for LOAD.
- dout holds 0 whenever dout_valid=0.
- Host port:
  - Writes on any cycle.
  - Same-cycle store to the same index: the store wins.
  - A host write to the index being read during DELAY: read returns old data (read-before-write).

Optional Feature:
- Macro: SERIAL_RESP_ERR_EN.
- Defined: error sets on any of:
  - bus_pc or bus_mar asserted in ADDR_CHK, DATA_LO, DELAY, RESP_*;
  - no strobe in PC_LO or ADDR_LO;
  - more than one strobe in the same cycle;
  - address[15:ADDR_W] nonzero.
  - error clears only on reset. FSM behaviour is otherwise unchanged.
- Undefined: error tied to 0; no checking logic is built.

Decomposition:
- serial_bus_pkg holds:
  - the resp_state_t enum (IDLE, PC_LO, ADDR_LO, ADDR_CHK, DATA_LO, DELAY, RESP_RDY, RESP_HI, RESP_LO);
  - the req_kind_t enum (FETCH, LOAD);
  - the BUS_W=8 constant.
- One sub-module, sresp_ram: dual-write, single synchronous read 16-bit RAM.
  - Store port has priority over the host port.
  - Read-before-write behaviour.

Test Plan:
- Fetch: preload [0x05]=0xA1B2; RESP_DELAY=2; PC beats 0x00,0x05 → ard_data_ready 3 cycles after the lo beat, then dout 0xA1, 0xB2 with dout_valid; ard_receive_ready=1 next cycle.
- Store then load: MAR 0x00,0x10; MDR 0xDE,0xAD → no response; RAM[0x10]=0xDEAD. Then MAR 0x00,0x10 with no MDR → response 0xDE,0xAD.
- RESP_DELAY=0: fetch → ard_data_ready exactly 2 cycles after PC lo beat.
- Reset mid-store: rst_n low during DATA_LO → RAM[0x10] unchanged; all outputs 0; ard_receive_ready=1 after release.
- Address wrap: ADDR_W=8, MAR 0x01,0x05 → reads index 0x05. With SERIAL_RESP_ERR_EN, error=1 and stays 1 until reset.
- Collision: host_we to 0x20 in the same cycle as a store to 0x20 → store data retained.
